// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: entry-state encoding, ALU opcodes
// and the decoded key-event bundle passed from the edge detector to the FSM.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        OPER    = 3'd1,
        ENTRY_B = 3'd2,
        REQ     = 3'd3,
        SHOW    = 3'd4
    } calc_state_e;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_MOD  = 3'd5;

    // At most one of the *_ev flags is set in any cycle.
    typedef struct packed {
        logic       submit_ev;
        logic       opt_ev;
        logic       digit_ev;
        logic [3:0] digit;
        logic [2:0] opcode;
    } key_evt_t;

endpackage

// File: rtl/key_edge_detect.sv
// Turns the three held key levels into single-cycle events, keeps the key
// codes aligned with the first sampling stage and resolves coinciding events.
module key_edge_detect
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] num_i,
    input  logic [2:0] opt_i,
    input  logic       num_pressed_i,
    input  logic       opt_pressed_i,
    input  logic       submit_i,
    output key_evt_t   evt_o
);

    // Bit order of the level pipeline: [2] submit, [1] operator, [0] digit.
    logic [2:0] s1_q;
    logic [2:0] s2_q;
    logic [3:0] num_q;
    logic [2:0] opt_q;
    logic [2:0] rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            num_q <= '0;
            opt_q <= '0;
        end else begin
            s1_q  <= {submit_i, opt_pressed_i, num_pressed_i};
            s2_q  <= s1_q;
            num_q <= num_i;
            opt_q <= opt_i;
        end
    end

    assign rise = s1_q & ~s2_q;

    // Priority picks the winner first; an invalid winner still suppresses the rest.
    always_comb begin
        evt_o        = '0;
        evt_o.digit  = num_q;
        evt_o.opcode = opt_q;
        if (rise[2]) begin
            evt_o.submit_ev = 1'b1;
        end else if (rise[1]) begin
            evt_o.opt_ev = (opt_q != OP_NONE);
        end else if (rise[0]) begin
            evt_o.digit_ev = (num_q <= 4'd9);
        end
    end

endmodule

// File: rtl/calc_input_controller.sv
// Calculator entry controller: builds two decimal operands from key events,
// runs one req/ack exchange with the ALU and holds the result for display.
module calc_input_controller
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       num,
    input  logic             numPressed,
    input  logic [2:0]       opt,
    input  logic             optPressed,
    input  logic             submit,
    output logic [WIDTH-1:0] operandA,
    output logic [WIDTH-1:0] operandB,
    output logic [2:0]       op,
    output logic             aluReq,
    input  logic             aluAck,
    input  logic [WIDTH-1:0] aluResult,
    input  logic             aluErr,
    output logic [WIDTH-1:0] dispValue,
    output logic             err,
    output calc_state_e      dbgState
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

    key_evt_t evt;

    key_edge_detect u_keys (
        .clk           (clk),
        .rst_n         (reset),
        .num_i         (num),
        .opt_i         (opt),
        .num_pressed_i (numPressed),
        .opt_pressed_i (optPressed),
        .submit_i      (submit),
        .evt_o         (evt)
    );

    calc_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d, req_q, req_d;

    // One accumulator serves whichever operand is currently being typed.
    logic [WIDTH-1:0] acc_base, acc_sum;
    logic             acc_room;

    assign acc_base = (state_q == ENTRY_B) ? b_q : a_q;
    assign acc_sum  = (acc_base << 3) + (acc_base << 1) + WIDTH'(evt.digit);
    assign acc_room = ((state_q == ENTRY_B) ? cnt_b_q : cnt_a_q) < CNT_FULL;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            ENTRY_A: begin
                if (evt.digit_ev && acc_room) begin
                    a_d     = acc_sum;
                    cnt_a_d = cnt_a_q + CW'(1);
                end else if (evt.opt_ev) begin
                    op_d    = evt.opcode;
                    state_d = OPER;
                end
            end
            OPER: begin
                if (evt.digit_ev) begin
                    b_d     = WIDTH'(evt.digit);
                    cnt_b_d = CW'(1);
                    state_d = ENTRY_B;
                end else if (evt.opt_ev) begin
                    op_d = evt.opcode;
                end
            end
            ENTRY_B: begin
                if (evt.digit_ev && acc_room) begin
                    b_d     = acc_sum;
                    cnt_b_d = cnt_b_q + CW'(1);
                end else if (evt.submit_ev) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (aluAck) begin
                    res_d   = aluResult;
                    err_d   = aluErr;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (evt.digit_ev) begin
                    err_d   = 1'b0;
                    a_d     = WIDTH'(evt.digit);
                    cnt_a_d = CW'(1);
                    b_d     = '0;
                    cnt_b_d = '0;
                    op_d    = OP_NONE;
                    state_d = ENTRY_A;
                end else if (evt.opt_ev && !err_q) begin
                    // A chained result is treated as a full operand: no digits append.
                    a_d     = res_q;
                    cnt_a_d = CNT_FULL;
                    op_d    = evt.opcode;
                    state_d = OPER;
                end
            end
            default: state_d = ENTRY_A;
        endcase
    end

    always_comb begin
        req_d = (state_d == REQ);
        case (state_d)
            ENTRY_A, OPER: disp_d = a_d;
            ENTRY_B, REQ:  disp_d = b_d;
            SHOW:          disp_d = res_d;
            default:       disp_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTRY_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            op_q    <= OP_NONE;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            op_q    <= op_d;
            err_q   <= err_d;
            req_q   <= req_d;
            disp_q  <= disp_d;
        end
    end

    assign operandA  = a_q;
    assign operandB  = b_q;
    assign op        = op_q;
    assign aluReq    = req_q;
    assign dispValue = disp_q;
    assign err       = err_q;
    assign dbgState  = state_q;

endmodule

// File: tb/tb_calc_input_controller.sv
// Bench for calc_input_controller: hand-derived vector table, corner-case
// sequences, and random key/ALU traffic checked against an event-level model.
module tb_calc_input_controller;
    import calc_pkg::*;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 14;
    localparam int K_DIG = 0, K_OPT = 1, K_SUB = 2, K_ACK = 3, K_ACKE = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       num;
    logic             numPressed;
    logic [2:0]       opt;
    logic             optPressed;
    logic             submit;
    logic [WIDTH-1:0] operandA, operandB, aluResult, dispValue;
    logic [2:0]       op;
    logic             aluReq, aluAck, aluErr, err;
    calc_state_e      dbgState;

    calc_input_controller #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .num(num), .numPressed(numPressed),
        .opt(opt), .optPressed(optPressed), .submit(submit),
        .operandA(operandA), .operandB(operandB), .op(op), .aluReq(aluReq),
        .aluAck(aluAck), .aluResult(aluResult), .aluErr(aluErr),
        .dispValue(dispValue), .err(err), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    calc_state_e m_state;
    int mA, mB, mLenA, mLenB, mOp, mRes, mErr;

    task automatic m_reset();
        m_state = ENTRY_A;
        mA = 0; mB = 0; mLenA = 0; mLenB = 0; mOp = 0; mRes = 0; mErr = 0;
    endtask

    task automatic m_event(input int kind, input int code);
        if (kind == K_DIG && code > 9) return;
        if (kind == K_OPT && code == 0) return;
        case (m_state)
            ENTRY_A:
                if (kind == K_DIG && mLenA < DIGITS) begin mA = mA * 10 + code; mLenA++; end
                else if (kind == K_OPT) begin mOp = code; m_state = OPER; end
            OPER:
                if (kind == K_DIG) begin mB = code; mLenB = 1; m_state = ENTRY_B; end
                else if (kind == K_OPT) mOp = code;
            ENTRY_B:
                if (kind == K_DIG && mLenB < DIGITS) begin mB = mB * 10 + code; mLenB++; end
                else if (kind == K_SUB) m_state = REQ;
            SHOW:
                if (kind == K_DIG) begin
                    mErr = 0; mA = code; mLenA = 1; mB = 0; mOp = 0; m_state = ENTRY_A;
                end else if (kind == K_OPT && mErr == 0) begin
                    mA = mRes; mLenA = DIGITS; mOp = code; m_state = OPER;
                end
            default: ;
        endcase
    endtask

    task automatic m_ack(input int r, input int e);
        if (m_state == REQ) begin mRes = r; mErr = e; m_state = SHOW; end
    endtask

    function automatic int m_disp();
        case (m_state)
            ENTRY_A, OPER: return mA;
            ENTRY_B, REQ:  return mB;
            default:       return mRes;
        endcase
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".operandA"},  operandA,  mA);
        chk({tag, ".operandB"},  operandB,  mB);
        chk({tag, ".op"},        op,        mOp);
        chk({tag, ".aluReq"},    aluReq,    (m_state == REQ) ? 1 : 0);
        chk({tag, ".dispValue"}, dispValue, m_disp());
        chk({tag, ".err"},       err,       mErr);
        chk({tag, ".state"},     dbgState,  m_state);
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        num = '0; opt = '0; numPressed = 0; optPressed = 0; submit = 0;
        aluAck = 0; aluErr = 0; aluResult = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_reset();
    endtask

    task automatic press(input bit d, input bit o, input bit s, input int n, input int p);
        @(negedge clk);
        num = 4'(n); opt = 3'(p);
        numPressed = d; optPressed = o; submit = s;
        repeat (2) @(negedge clk);
        numPressed = 0; optPressed = 0; submit = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ack_pulse(input int r, input bit e);
        @(negedge clk);
        aluAck = 1'b1; aluResult = WIDTH'(r); aluErr = e;
        @(negedge clk);
        aluAck = 1'b0; aluResult = '0; aluErr = 1'b0;
    endtask

    task automatic apply(input int kind, input int code);
        case (kind)
            K_DIG:   press(1, 0, 0, code, 0);
            K_OPT:   press(0, 1, 0, 0, code);
            K_SUB:   press(0, 0, 1, 0, 0);
            K_ACK:   ack_pulse(code, 1'b0);
            default: ack_pulse(code, 1'b1);
        endcase
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int kind; int code;
        int ea; int eb; int eop; int edisp;
        calc_state_e est; int ereq; int eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int k, int c, int a, int b, int o, int dsp,
                                calc_state_e st, int rq, int er);
        vec_t v;
        v.kind = k; v.code = c; v.ea = a; v.eb = b; v.eop = o; v.edisp = dsp;
        v.est = st; v.ereq = rq; v.eerr = er;
        return v;
    endfunction

    initial begin
        tbl.push_back(mk(K_DIG, 1,    1,  0, 0,    1, ENTRY_A, 0, 0));
        tbl.push_back(mk(K_DIG, 2,   12,  0, 0,   12, ENTRY_A, 0, 0));
        tbl.push_back(mk(K_OPT, 1,   12,  0, 1,   12, OPER,    0, 0));
        tbl.push_back(mk(K_DIG, 3,   12,  3, 1,    3, ENTRY_B, 0, 0));
        tbl.push_back(mk(K_DIG, 4,   12, 34, 1,   34, ENTRY_B, 0, 0));
        tbl.push_back(mk(K_SUB, 0,   12, 34, 1,   34, REQ,     1, 0));
        tbl.push_back(mk(K_ACK, 46,  12, 34, 1,   46, SHOW,    0, 0));
        tbl.push_back(mk(K_OPT, 3,   46, 34, 3,   46, OPER,    0, 0));
        tbl.push_back(mk(K_DIG, 9,   46,  9, 3,    9, ENTRY_B, 0, 0));
        tbl.push_back(mk(K_SUB, 0,   46,  9, 3,    9, REQ,     1, 0));
        tbl.push_back(mk(K_ACKE, 5,  46,  9, 3,    5, SHOW,    0, 1));
        tbl.push_back(mk(K_OPT, 2,   46,  9, 3,    5, SHOW,    0, 1));
        tbl.push_back(mk(K_SUB, 0,   46,  9, 3,    5, SHOW,    0, 1));
        tbl.push_back(mk(K_DIG, 8,    8,  0, 0,    8, ENTRY_A, 0, 0));
        tbl.push_back(mk(K_OPT, 0,    8,  0, 0,    8, ENTRY_A, 0, 0));
        tbl.push_back(mk(K_DIG, 1,   81,  0, 0,   81, ENTRY_A, 0, 0));
        tbl.push_back(mk(K_DIG, 2,  812,  0, 0,  812, ENTRY_A, 0, 0));
        tbl.push_back(mk(K_DIG, 3, 8123,  0, 0, 8123, ENTRY_A, 0, 0));
        tbl.push_back(mk(K_DIG, 5, 8123,  0, 0, 8123, ENTRY_A, 0, 0));
        tbl.push_back(mk(K_SUB, 0, 8123,  0, 0, 8123, ENTRY_A, 0, 0));
        tbl.push_back(mk(K_OPT, 1, 8123,  0, 1, 8123, OPER,    0, 0));
        tbl.push_back(mk(K_OPT, 2, 8123,  0, 2, 8123, OPER,    0, 0));
        tbl.push_back(mk(K_DIG, 2, 8123,  2, 2,    2, ENTRY_B, 0, 0));
        tbl.push_back(mk(K_DIG, 12, 8123, 2, 2,    2, ENTRY_B, 0, 0));
        tbl.push_back(mk(K_OPT, 4, 8123,  2, 2,    2, ENTRY_B, 0, 0));
        tbl.push_back(mk(K_DIG, 7, 8123, 27, 2,   27, ENTRY_B, 0, 0));
        tbl.push_back(mk(K_SUB, 0, 8123, 27, 2,   27, REQ,     1, 0));
        tbl.push_back(mk(K_ACK, 100, 8123, 27, 2, 100, SHOW,   0, 0));
        tbl.push_back(mk(K_ACK, 55, 8123, 27, 2,  100, SHOW,   0, 0));
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        num = '0; opt = '0; numPressed = 0; optPressed = 0; submit = 0;
        aluAck = 0; aluErr = 0; aluResult = '0;
        m_reset();

        do_reset();
        @(negedge clk);
        check_model("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].kind, tbl[i].code);
            chk($sformatf("vec%0d.operandA", i),  operandA,  tbl[i].ea);
            chk($sformatf("vec%0d.operandB", i),  operandB,  tbl[i].eb);
            chk($sformatf("vec%0d.op", i),        op,        tbl[i].eop);
            chk($sformatf("vec%0d.dispValue", i), dispValue, tbl[i].edisp);
            chk($sformatf("vec%0d.state", i),     dbgState,  tbl[i].est);
            chk($sformatf("vec%0d.aluReq", i),    aluReq,    tbl[i].ereq);
            chk($sformatf("vec%0d.err", i),       err,       tbl[i].eerr);
        end

        // Long hold gives one event; a second press gives exactly one more.
        do_reset();
        @(negedge clk);
        num = 4'd7; numPressed = 1'b1;
        repeat (100) @(negedge clk);
        chk("hold.operandA", operandA, 7);
        numPressed = 1'b0;
        repeat (2) @(negedge clk);
        press(1, 0, 0, 7, 0);
        chk("repress.operandA", operandA, 77);
        chk("repress.dispValue", dispValue, 77);

        // Level already high when reset releases.
        @(negedge clk);
        reset = 1'b0;
        num = 4'd5; numPressed = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("held_at_reset.operandA", operandA, 5);
        repeat (5) @(negedge clk);
        chk("held_at_reset.once", operandA, 5);
        numPressed = 1'b0;
        repeat (2) @(negedge clk);

        // Ack in the very first REQ cycle.
        do_reset();
        press(1, 0, 0, 3, 0);
        press(0, 1, 0, 0, 1);
        press(1, 0, 0, 4, 0);
        @(negedge clk);
        submit = 1'b1;
        repeat (2) @(negedge clk);
        chk("first_req.aluReq", aluReq, 1);
        chk("first_req.state", dbgState, REQ);
        aluAck = 1'b1; aluResult = WIDTH'(7);
        @(negedge clk);
        aluAck = 1'b0; submit = 1'b0;
        chk("first_ack.state", dbgState, SHOW);
        chk("first_ack.aluReq", aluReq, 0);
        chk("first_ack.dispValue", dispValue, 7);

        // Asynchronous reset in the middle of a request.
        press(1, 0, 0, 2, 0);
        press(0, 1, 0, 0, 2);
        press(1, 0, 0, 6, 0);
        press(0, 0, 1, 0, 0);
        chk("pre_reset.aluReq", aluReq, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        m_reset();
        check_model("async_reset");
        @(negedge clk);
        reset = 1'b1;
        ack_pulse(99, 1'b1);
        check_model("late_ack");

        // Random traffic against the model.
        do_reset();
        for (int it = 0; it < 90; it++) begin
            int sel, c;
            bit d, o, s;
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                c = $urandom_range(0, 11);
                press(1, 0, 0, c, 0);
                m_event(K_DIG, c);
            end else if (sel <= 6) begin
                c = $urandom_range(0, 5);
                press(0, 1, 0, 0, c);
                m_event(K_OPT, c);
            end else if (sel == 7) begin
                press(0, 0, 1, 0, 0);
                m_event(K_SUB, 0);
            end else if (sel == 8) begin
                int n, p;
                d = 1'($urandom_range(0, 1));
                o = 1'($urandom_range(0, 1));
                s = 1'($urandom_range(0, 1));
                n = $urandom_range(0, 11);
                p = $urandom_range(0, 5);
                press(d, o, s, n, p);
                if (s) m_event(K_SUB, 0);
                else if (o) m_event(K_OPT, p);
                else if (d) m_event(K_DIG, n);
            end else begin
                c = $urandom_range(0, (1 << WIDTH) - 1);
                ack_pulse(c, 1'($urandom_range(0, 1)));
                m_ack(c, 0);
            end
            check_model($sformatf("rnd%0d", it));
            if (m_state == REQ) begin
                int wait_n, e;
                wait_n = $urandom_range(0, 3);
                for (int w = 0; w < wait_n; w++) begin
                    @(negedge clk);
                    chk($sformatf("rnd%0d.req_hold", it), aluReq, 1);
                end
                c = $urandom_range(0, (1 << WIDTH) - 1);
                e = ($urandom_range(0, 3) == 0) ? 1 : 0;
                ack_pulse(c, 1'(e));
                m_ack(c, e);
                check_model($sformatf("rnd%0d.ack", it));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_input_controller.md
# calc_input_controller

Sequencing controller between `KeyboardDecoder` and the calculator ALU. It turns held key levels (`numPressed`, `optPressed`, `submit`) into single events and builds two decimal operands digit by digit. On submit it issues one request/acknowledge transaction to the ALU, then holds the result for display. It owns the calculator's entry state machine and drives the display value.

## Interface
Parameters:
- `DIGITS`, 4: maximum decimal digits per operand.
- `WIDTH`, 14: operand and result width. Must satisfy 2^WIDTH > 10^DIGITS − 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `num`  in  4  key code from the decoder; a digit when ≤ 9.
- `numPressed`  in  1  level, high while a digit key is held.
- `opt`  in  3  operator code 1..5; 0 means none.
- `optPressed`  in  1  level, high while an operator key is held.
- `submit`  in  1  level, high while the submit key is held.
- `operandA`  out  WIDTH  first operand.
- `operandB`  out  WIDTH  second operand.
- `op`  out  3  latched operator code.
- `aluReq`  out  1  compute request.
- `aluAck`  in  1  one-cycle pulse; the result is valid in that cycle.
- `aluResult`  in  WIDTH  ALU result.
- `aluErr`  in  1  ALU error flag, sampled together with `aluAck`.
- `dispValue`  out  WIDTH  value to display.
- `err`  out  1  latched error from the last computation.

## Operation
- Event detection:
  - Each level input is registered into `s1` and then `s2`; an event is `s1 & ~s2`.
  - `num` and `opt` are registered with their levels.
  - A held key produces exactly one event. Re-pressing requires the level to be low for at least one sampled cycle.
  - Priority when events coincide: submit > operator > digit. Lower-priority events in that cycle are dropped.
  - An operator event with `opt`=0 is ignored, and so is a digit event with `num` > 9.
- Digit accumulate: `X <= X*10 + d` when the digit count is below `DIGITS`. Otherwise the digit is dropped and X is unchanged.
- States: ENTRY_A, OPER, ENTRY_B, REQ, SHOW.
- ENTRY_A:
  - digit: accumulate into A.
  - operator: `op <= opt`, go to OPER.
  - submit: ignored.
- OPER:
  - digit: `B <= d`, count = 1, go to ENTRY_B.
  - operator: replaces `op`.
  - submit: ignored.
- ENTRY_B:
  - digit: accumulate into B.
  - operator: ignored.
  - submit: go to REQ.
- REQ:
  - `aluReq` = 1; operands and `op` are frozen.
  - All key events are ignored.
  - On `aluAck`: capture `aluResult` and `aluErr`, go to SHOW.
- SHOW:
  - digit: clear `err`, `A <= d`, `B <= 0`, count = 1, `op <= 0`, go to ENTRY_A.
  - operator with `err`=0: `A <= result`, count = `DIGITS` (no further digits append), `op <= opt`, go to OPER.
  - operator with `err`=1: ignored.
  - submit: ignored.
- `dispValue` by state: A in ENTRY_A and OPER; B in ENTRY_B and REQ; result in SHOW.
- `aluAck` outside REQ is ignored.
- Reset values: all registers 0, state ENTRY_A. So `operandA`, `operandB`, `op`, `aluReq`, `dispValue` and `err` all reset to 0.

## Timing
- Latency from key level to state/output change:
  - A level first high before edge N is sampled into `s1` at edge N.
  - The event is decoded in cycle N.
  - State and outputs update at edge N+1.
- All outputs are registered. `aluReq` is a Moore output: high from the edge entering REQ until the edge following the `aluAck` cycle.
- `aluAck` is accepted in any REQ cycle, including the first.
- `aluResult` and `aluErr` are sampled only in the `aluAck` cycle.
- Reset mid-operation: asynchronous clear of everything. `aluReq` drops without waiting for a clock edge. A late `aluAck` arriving after reset is ignored.
- Levels already high when reset releases: the synchronizer registers reset to 0, so the held key produces one event on the first edge after reset release.

## Structure
- Shared package `calc_pkg` holds:
  - state encoding constants: ENTRY_A, OPER, ENTRY_B, REQ, SHOW;
  - opcode constants: OP_NONE=0, OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4, OP_MOD=5.
  - The ALU uses the same opcode constants.
- Sub-module `key_edge_detect`: 3-bit level-to-pulse unit with registered `num`/`opt` capture and the priority resolution. It is instantiated once.
- The top level contains the FSM, the two digit counters and the `*10 + d` accumulator, shared between A and B.

## Test plan
- Keys 1, 2, opt 1, 3, 4, submit, then `aluAck` with `aluResult`=46 → `operandA`=12, `operandB`=34, `op`=1, and `aluReq` high until the ack. After that `dispValue`=46 and state is SHOW.
- Digits 1, 2, 3, 4, 5 in ENTRY_A → `operandA`=1234 and `dispValue`=1234; the fifth digit is dropped.
- `numPressed` held 100 cycles with `num`=7, then a second press of 7 → A=7 after the hold, A=77 after the second press; exactly two events.
- Key 7, opt 1, opt 2, key 2 → `op`=2, `operandB`=2.
- From SHOW with result 46: opt 3 → `operandA`=46, `op`=3, state OPER, and a following digit 9 gives B=9. A repeat run with `aluErr`=1 at ack → `err`=1 and the opt press is ignored.
- `reset` asserted low during REQ, mid-cycle → `aluReq` is 0 before the next clock edge and all outputs read 0. An `aluAck` pulse after reset release causes no change.
